flash_stream_prefetch: RTL and testbench
========================================

Name: flash_stream_prefetch

Overview:
- Sits between dspi_flash_reader and the UART transmit path (uart_tx or uart_tx_hex).
- On a start command it issues a burst of single-byte flash reads at incrementing addresses and buffers the returned bytes in a small FIFO.
- It presents the bytes as a first-word-fall-through stream, so the UART side drains a contiguous region without per-byte control logic in top.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, minimum 2
LEN_W, 16, width of the burst length field
ADDR_W, 24, flash address width

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle burst request; sampled only in IDLE
start_addr  in  ADDR_W  first byte address, latched on accepted start
start_len  in  LEN_W  byte count, latched on accepted start; 0 = empty burst
abort  in  1  terminate burst; FIFO contents discarded
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the burst completes or an abort finishes
fl_read  out  1  one-cycle read pulse to the flash reader
fl_addr  out  ADDR_W  read address; stable from fl_read until fl_ready
fl_ready  in  1  one-cycle pulse from the flash reader; fl_data valid
fl_data  in  8  byte returned by the flash reader
out_valid  out  1  FIFO non-empty
out_data  out  8  FIFO head byte; valid while out_valid
out_pop  in  1  consumer took the head; ignored when out_valid=0

Behaviour:
- Reset: async assert, sync-style release.
  - Reset values: state=IDLE, busy=0, done=0, fl_read=0, fl_addr=0, FIFO empty, out_valid=0, out_data=0, remaining=0.
- States: IDLE, WAIT, REQ, DRAIN, ABORT.
- IDLE:
  - start with start_len!=0: latch fl_addr=start_addr and remaining=start_len; next cycle fl_read=1 (single cycle); go to WAIT. The FIFO is guaranteed empty in IDLE.
  - start with start_len=0: done pulses the next cycle; stay in IDLE.
- WAIT (one read is outstanding):
  - On fl_ready: push fl_data, fl_addr+=1 (wraps modulo 2^ADDR_W), remaining-=1.
  - If remaining was 1: go to DRAIN.
  - Else if the FIFO occupancy after the push and any same-cycle pop is < DEPTH: fl_read=1 next cycle, stay in WAIT.
  - Else: go to REQ.
- REQ: when occupancy < DEPTH, fl_read=1 next cycle and go to WAIT. At most one read is ever outstanding, so a push can never overflow.
- DRAIN: when the FIFO is empty (including the cycle in which the last pop empties it), done pulses the next cycle and the state goes to IDLE.
- Abort:
  - In REQ or DRAIN: flush the FIFO immediately, done next cycle, go to IDLE.
  - In WAIT: go to ABORT. ABORT waits for fl_ready, discards that byte, flushes the FIFO, pulses done and goes to IDLE. A flash transaction in flight cannot be cancelled.
  - In IDLE: ignored.
- busy covers ABORT.
- start while busy: ignored.
- start and abort in the same IDLE cycle: start wins.
- FIFO:
  - Simultaneous push and pop at any occupancy, including full, is legal; occupancy is unchanged.
  - Pop on empty has no effect.
  - out_data/out_valid are FWFT: a byte pushed on cycle n is visible on cycle n+1.
- Throughput: a read is issued 1 cycle after each fl_ready while space remains.
- Reset mid-burst: everything returns to reset values; top resets the flash reader on the same rstn.

Decomposition:
- Shared package: state encoding (IDLE=0, WAIT=1, REQ=2, DRAIN=3, ABORT=4), default DEPTH/LEN_W/ADDR_W, and the flash base-address constant 24'h400000 used by top.
- Sub-module sync_fifo (WIDTH, DEPTH), with ports clk, rstn, push, din, pop, flush, dout, empty, full, count. It is reusable for the UART receive path.

Test Plan:
- start_addr=0x400000, len=4, out_pop held 1; flash model returns addr[7:0] → fl_addr sequence 400000..400003, out_data 00,01,02,03, exactly 4 fl_read pulses, done once, busy low afterwards.
- DEPTH=8, len=20, out_pop=0 → exactly 8 reads, then REQ stall with no fl_read. Pop one byte → exactly one new fl_read on the following cycle. Total reads 20, no overflow.
- start_addr=0xFFFFFE, len=4 → fl_addr FFFFFE, FFFFFF, 000000, 000001.
- start_len=0 → done 1 cycle after start, fl_read never asserted, busy stays 0.
- abort in WAIT with fl_ready 10 cycles later → no fl_read after the abort, out_valid=0 after fl_ready, done on the cycle after fl_ready. A new start is then accepted normally.
- rstn pulsed low mid-burst with the FIFO holding 5 bytes → outputs return to reset values immediately. A start after release reads from its new start_addr.

Source files
------------

// File: rtl/flash_stream_prefetch_pkg.sv
// Shared definitions for the flash stream prefetcher.
//   state_e     : FSM state encoding, also exposed on the dbg_state output
//   DEF_*       : default parameter values for DEPTH / LEN_W / ADDR_W
//   FLASH_BASE  : base address of the user region in the serial flash
package flash_stream_prefetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REQ   = 3'd2,
    S_DRAIN = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_ADDR_W = 24;

  localparam logic [23:0] FLASH_BASE = 24'h400000;

endpackage

// File: rtl/flash_stream_prefetch_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rstn : clock, asynchronous active-low reset
//   push, din : write strobe and data; ignored when full unless a pop happens too
//   pop       : consume head; ignored when empty
//   flush     : synchronous clear; wins over push/pop in the same cycle
//   dout      : head entry (reads 0 while empty)
//   empty, full, count : occupancy status
// Handshake: an entry written on cycle n is visible on dout on cycle n+1.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/flash_stream_prefetch.sv
// Burst prefetcher from the flash reader into a FWFT byte stream.
//   clk, rstn                       : clock, asynchronous active-low reset
//   start, start_addr, start_len    : burst request (IDLE only); len 0 = empty burst
//   abort                           : terminate burst, buffered bytes discarded
//   busy, done                      : state != IDLE; one-cycle completion pulse
//   fl_read, fl_addr                : read pulse / address to the flash reader
//   fl_ready, fl_data               : response pulse / byte from the flash reader
//   out_valid, out_data, out_pop    : FWFT stream to the consumer
//   dbg_state                       : current FSM state
// Handshake: out_data is valid while out_valid=1; the byte is consumed on a
// cycle with out_valid=1 and out_pop=1. out_pop with out_valid=0 is ignored.
// At most one flash read is outstanding, and a read is only issued while the
// FIFO has room for its byte, so the FIFO can never overflow.
module flash_stream_prefetch
  import flash_stream_prefetch_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              fl_read,
  output logic [ADDR_W-1:0] fl_addr,
  input  logic              fl_ready,
  input  logic [7:0]        fl_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_pop,
  output state_e            dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e           state;
  logic [LEN_W-1:0] remaining;
  logic             fifo_push;
  logic             fifo_flush;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop_eff;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    count_after;

  assign busy      = (state != S_IDLE);
  assign out_valid = ~fifo_empty;
  assign dbg_state = state;

  assign pop_eff   = out_pop & ~fifo_empty;
  // A byte arriving together with abort is dropped along with the rest.
  assign fifo_push = (state == S_WAIT) & fl_ready & ~abort;
  assign fifo_flush = (abort & ((state == S_REQ) | (state == S_DRAIN) |
                                ((state == S_WAIT) & fl_ready))) |
                      ((state == S_ABORT) & fl_ready);
  // Occupancy as it will be after this cycle's push and pop.
  assign count_after = fifo_count + CW'(fifo_push) - CW'(pop_eff);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   (fl_data),
    .pop   (out_pop),
    .flush (fifo_flush),
    .dout  (out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      fl_read   <= 1'b0;
      fl_addr   <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      fl_read <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_len != '0) begin
              fl_addr   <= start_addr;
              remaining <= start_len;
              fl_read   <= 1'b1;
              state     <= S_WAIT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (abort) begin
            // If the outstanding response lands in the abort cycle there is
            // nothing left to wait for.
            if (fl_ready) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_ABORT;
            end
          end else if (fl_ready) begin
            fl_addr   <= fl_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= S_DRAIN;
            end else if (count_after < CW'(DEPTH)) begin
              fl_read <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (abort) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (!fifo_full || pop_eff) begin
            fl_read <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_DRAIN: begin
          if (abort || count_after == '0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ABORT: begin
          if (fl_ready) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_stream_prefetch.sv
// Self-checking bench for flash_stream_prefetch: directed scenarios plus
// randomized bursts, checked against an address/byte-sequence model.
module tb_flash_stream_prefetch;
  import flash_stream_prefetch_pkg::*;

  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        start;
  logic [23:0] start_addr;
  logic [15:0] start_len;
  logic        abort;
  logic        busy;
  logic        done;
  logic        fl_read;
  logic [23:0] fl_addr;
  logic        fl_ready;
  logic [7:0]  fl_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_pop;
  state_e      dbg_state;

  flash_stream_prefetch #(.DEPTH(DEPTH), .LEN_W(16), .ADDR_W(24)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .fl_read    (fl_read),
    .fl_addr    (fl_addr),
    .fl_ready   (fl_ready),
    .fl_data    (fl_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_pop    (out_pop),
    .dbg_state  (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];      // bytes the consumer should see, in order
  logic [23:0] exp_addr;      // next address the DUT should read
  int reads = 0, pops = 0, readies = 0, done_cnt = 0, cyc = 0;
  int ready_cyc = 0, done_cyc = 0;
  int base_reads = 0, base_pops = 0, base_readies = 0;
  int flash_lat = 0;          // 0 = random 1..4 cycles
  int pop_mode = 0;           // 0 manual, 1 always pop, 2 random

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- flash reader model ----------------
  logic        pend;
  int          cnt;
  logic [23:0] paddr;
  initial begin
    fl_ready = 1'b0;
    fl_data  = 8'h00;
    pend     = 1'b0;
    cnt      = 0;
    paddr    = '0;
    forever begin
      @(posedge clk); #1;
      fl_ready = 1'b0;
      if (!rstn) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          fl_ready = 1'b1;
          fl_data  = paddr[7:0];
          pend     = 1'b0;
        end else begin
          cnt--;
        end
      end else if (fl_read) begin
        pend  = 1'b1;
        paddr = fl_addr;
        cnt   = (flash_lat == 0) ? int'($urandom_range(0, 3)) : flash_lat - 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (fl_read) begin
        reads++;
        chk("fl_addr", 32'(fl_addr), 32'(exp_addr));
        exp_addr = exp_addr + 24'd1;
        // reads issued minus bytes consumed bounds FIFO occupancy
        checks++;
        assert ((reads - base_reads) - (pops - base_pops) <= DEPTH) else begin
          errors++;
          $error("FAIL occupancy observed %0d expected <= %0d",
                 (reads - base_reads) - (pops - base_pops), DEPTH);
        end
      end
      if (fl_ready) begin
        readies++;
        ready_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_pop && out_valid) begin
        pops++;
        if (exp_q.size() == 0) chk("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (pop_mode == 1) out_pop = 1'b1;
      else if (pop_mode == 2) out_pop = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] l);
    logic [23:0] t;
    exp_addr     = a;
    base_reads   = reads;
    base_pops    = pops;
    base_readies = readies;
    exp_q.delete();
    for (int i = 0; i < int'(l); i++) begin
      t = a + 24'(i);
      exp_q.push_back(t[7:0]);
    end
    start = 1'b1; start_addr = a; start_len = l;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) step(1);
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_fl_read"},  32'(fl_read), 0);
    chk({tag, "_fl_addr"},  32'(fl_addr), 0);
    chk({tag, "_out_valid"},32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_state"},    32'(dbg_state), 32'(S_IDLE));
  endtask

  task automatic random_burst(input logic [23:0] a, input logic [15:0] l);
    int d0;
    d0 = done_cnt;
    pop_mode = 2;
    do_start(a, l);
    wait_done(int'(l) * 20 + 100);
    step(2);
    chk("rb_reads",  32'(reads - base_reads), 32'(l));
    chk("rb_left",   32'(exp_q.size()), 0);
    chk("rb_busy",   32'(busy), 0);
    chk("rb_donecnt",32'(done_cnt - d0), 1);
    pop_mode = 0; out_pop = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0, r0;
    rstn = 1'b0; start = 1'b0; start_addr = '0; start_len = '0;
    abort = 1'b0; out_pop = 1'b0;
    step(3);
    check_reset_vals("rst");
    rstn = 1'b1;
    step(2);

    // 1: short burst from the flash base, consumer always ready
    d0 = done_cnt;
    pop_mode = 1;
    do_start(FLASH_BASE, 16'd4);
    wait_done(200);
    step(2);
    chk("t1_reads", 32'(reads - base_reads), 4);
    chk("t1_pops",  32'(pops - base_pops), 4);
    chk("t1_done",  32'(done_cnt - d0), 1);
    chk("t1_busy",  32'(busy), 0);
    pop_mode = 0; out_pop = 1'b0;

    // 2: FIFO fills, reads stall, one pop buys exactly one read
    do_start(24'h001000, 16'd20);
    for (int i = 0; i < 300 && (reads - base_reads) < DEPTH; i++) step(1);
    step(20);
    chk("t2_stall_reads", 32'(reads - base_reads), DEPTH);
    chk("t2_busy",        32'(busy), 1);
    chk("t2_valid",       32'(out_valid), 1);
    out_pop = 1'b1; step(1); out_pop = 1'b0;
    step(8);
    chk("t2_one_more",    32'(reads - base_reads), DEPTH + 1);
    pop_mode = 2;
    wait_done(2000);
    step(2);
    chk("t2_total",       32'(reads - base_reads), 20);
    chk("t2_left",        32'(exp_q.size()), 0);
    pop_mode = 0; out_pop = 1'b0;

    // 3: address wrap
    random_burst(24'hFFFFFE, 16'd4);

    // 4: empty burst
    d0 = done_cnt;
    do_start(24'h123456, 16'd0);
    chk("t4_done_pulse", 32'(done), 1);
    chk("t4_busy",       32'(busy), 0);
    step(5);
    chk("t4_reads",      32'(reads - base_reads), 0);
    chk("t4_donecnt",    32'(done_cnt - d0), 1);

    // 5: abort while a read is outstanding
    flash_lat = 10;
    do_start(24'h002000, 16'd8);
    step(1);
    abort = 1'b1; step(1); abort = 1'b0;
    r0 = reads;
    wait_done(60);
    chk("t5_no_read",     32'(reads - r0), 0);
    chk("t5_reads",       32'(reads - base_reads), 1);
    chk("t5_done_timing", 32'(done_cyc), 32'(ready_cyc + 1));
    chk("t5_valid",       32'(out_valid), 0);
    chk("t5_busy",        32'(busy), 0);
    exp_q.delete();
    flash_lat = 0;
    random_burst(24'h003000, 16'd6);

    // 6: reset while the FIFO holds five bytes
    do_start(24'h004000, 16'd20);
    for (int i = 0; i < 300 && (readies - base_readies) < 5; i++) step(1);
    chk("t6_filled", 32'(readies - base_readies), 5);
    rstn = 1'b0;
    #1;
    check_reset_vals("t6");
    exp_q.delete();
    step(2);
    rstn = 1'b1;
    step(1);
    random_burst(24'h00ABC0, 16'd5);

    // random bursts
    for (int k = 0; k < 6; k++)
      random_burst(24'($urandom()), 16'($urandom_range(1, 24)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
